lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter MAX_FAIL, default 3: consecutive failed verifications that trigger lockout (range 1-3).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 1000: lockout duration in clk cycles (1 to 2^16-1).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port key_valid, input, 1: one-cycle strobe; a new keypad result is on in_code.
REQ-006 SHALL have port in_code, input, 2: key result. 00 = digit matches stored digit; 01 = digit mismatches; 10 = '*'; 11 = '#'.
REQ-007 SHALL have port st, output, 5: registered state code, fed back to the input generator for RAM address and write-enable decode.
REQ-008 SHALL have port unlocked, output, 1: high while in state OPEN.
REQ-009 SHALL have port alarm, output, 1: high while in state LOCKOUT.
REQ-010 SHALL have port fail_cnt, output, 2: current consecutive-failure count.

Function
REQ-011 SHALL use these st codes: IDLE=00000; V1-V4=00001-00100 (1-4 digits entered); OPEN=00101; S0-S4=00110-01010 (0-4 new digits entered); LOCKOUT=01011.
REQ-012 SHALL keep a sticky err_flag: cleared on entry to V1, then ORed with (in_code==01) on each digit accepted in V1-V4.
REQ-013 SHALL change state only on clock edges where key_valid=1, except for the lockout timer; a held key_valid counts as one key per cycle.
REQ-014 IDLE: digit -> V1, with err_flag = (in_code==01); '*' and '#' ignored.
REQ-015 V1-V3: digit -> next V state; '*' -> IDLE with no failure counted; '#' -> failure.
REQ-016 V4: '#' with err_flag=0 -> OPEN and fail_cnt=0; '#' with err_flag=1 -> failure; '*' -> IDLE; digits ignored.
REQ-017 Failure: fail_cnt increments. If the new value equals MAX_FAIL -> LOCKOUT; otherwise -> IDLE.
REQ-018 OPEN: '*' -> S0; '#' -> IDLE (relock); digits ignored.
REQ-019 S0-S3: any digit (00 or 01) -> next S state; '*' -> OPEN (abort); '#' ignored.
REQ-020 S4: '#' -> IDLE (new password committed); '*' -> OPEN; digits ignored.
REQ-021 LOCKOUT: all keys ignored; exit behaviour per REQ-026/027.
REQ-022 Outputs SHALL be registered and SHALL reflect the new state in the cycle after the accepting edge; no combinational path from in_code to outputs.
REQ-023 fail_cnt SHALL saturate at MAX_FAIL and SHALL never wrap.

Reset
REQ-024 On a clk edge with reset=1: st=IDLE, err_flag=0, fail_cnt=0, timer=0, unlocked=0, alarm=0. Reset SHALL win over a simultaneous key_valid.
REQ-025 Reset mid-sequence (any V or S state, or LOCKOUT) SHALL discard partial entry and return to IDLE.

Configuration
REQ-026 With LOCK_CTRL_LOCKOUT_TIMER_EN defined: a 16-bit timer clears on entry to LOCKOUT and counts each cycle; at count LOCKOUT_CYCLES-1 the block SHALL go to IDLE with fail_cnt=0.
REQ-027 Without LOCK_CTRL_LOCKOUT_TIMER_EN: no timer logic; LOCKOUT SHALL persist until reset.

Structure
REQ-028 Package lock_pkg SHALL hold the st state-code constants/enum and the in_code constants (CODE_MATCH, CODE_MISS, CODE_STAR, CODE_HASH).
REQ-029 The timer SHALL be a sub-module lockout_timer (inputs start and enable; output done), instantiated only under the macro.

Verification
REQ-030 Reset, then keys 00,00,00,00,11 -> st steps 1,2,3,4,5; unlocked=1 one cycle after the '#' edge; fail_cnt=0.
REQ-031 Keys 00,01,00,00,11 -> st=IDLE, fail_cnt=1; repeated twice more (MAX_FAIL=3) -> st=01011, alarm=1.
REQ-032 With macro and LOCKOUT_CYCLES=10: alarm high for exactly 10 cycles, then st=IDLE and fail_cnt=0. Without macro: alarm still high after 100 cycles.
REQ-033 From OPEN: keys 10,01,00,01,00,11 -> st passes 6,7,8,9,10, then IDLE; unlocked=0.
REQ-034 In V2, assert reset and key_valid (in_code=00) on the same edge -> st=IDLE, fail_cnt=0. In V2, key 11 -> failure counted.
REQ-035 In LOCKOUT, key_valid pulses with every in_code value -> st unchanged, fail_cnt unchanged.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller.
//   st_e         : 5-bit state codes driven on lock_ctrl.st (the input generator decodes these
//                  for RAM address and write-enable, so the encodings are fixed).
//   CODE_*       : meaning of the 2-bit in_code key result.
package lock_pkg;

  typedef enum logic [4:0] {
    StIdle    = 5'd0,
    StV1      = 5'd1,
    StV2      = 5'd2,
    StV3      = 5'd3,
    StV4      = 5'd4,
    StOpen    = 5'd5,
    StS0      = 5'd6,
    StS1      = 5'd7,
    StS2      = 5'd8,
    StS3      = 5'd9,
    StS4      = 5'd10,
    StLockout = 5'd11
  } st_e;

  localparam logic [1:0] CODE_MATCH = 2'b00;
  localparam logic [1:0] CODE_MISS  = 2'b01;
  localparam logic [1:0] CODE_STAR  = 2'b10;
  localparam logic [1:0] CODE_HASH  = 2'b11;

  // Digits are the two codes with the top bit clear.
  function automatic logic is_digit(input logic [1:0] code);
    return ~code[1];
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout duration timer.
//   clk, reset : clock and synchronous active-high reset
//   start      : holds the count at zero (asserted while not in lockout)
//   enable     : counts one per cycle while high
//   done       : high on the cycle the count reaches LOCKOUT_CYCLES-1
// Only instantiated when LOCK_CTRL_LOCKOUT_TIMER_EN is defined.
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic done
);

  localparam logic [15:0] LastCount = 16'(LOCKOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign done = enable && (cnt_q == LastCount);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: 4-digit verification, open/relock, new-password entry and lockout
// after MAX_FAIL consecutive failed verifications.
//   clk, reset : clock and synchronous active-high reset
//   key_valid  : one-cycle strobe, in_code holds a new key result
//   in_code    : 00 match, 01 mismatch, 10 '*', 11 '#'
//   st         : registered state code (see lock_pkg::st_e)
//   unlocked   : high while in OPEN
//   alarm      : high while in LOCKOUT
//   fail_cnt   : consecutive failed verifications, saturates at MAX_FAIL
// Build option LOCK_CTRL_LOCKOUT_TIMER_EN: when defined, LOCKOUT ends after LOCKOUT_CYCLES
// cycles and clears fail_cnt; otherwise LOCKOUT holds until reset.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] in_code,
  output logic [4:0] st,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] fail_cnt
);

  if (MAX_FAIL < 1 || MAX_FAIL > 3 || LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535)
  begin : gen_bad_param
    $error("lock_ctrl: parameter out of range");
  end

  localparam logic [1:0] MaxFail = 2'(MAX_FAIL);

  st_e        st_q;
  logic       err_flag_q;
  logic [1:0] fail_inc;
  logic       timer_done;

  assign fail_inc = (fail_cnt >= MaxFail) ? MaxFail : fail_cnt + 2'd1;

`ifdef LOCK_CTRL_LOCKOUT_TIMER_EN
  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk   (clk),
    .reset (reset),
    .start (st_q != StLockout),
    .enable(st_q == StLockout),
    .done  (timer_done)
  );
`else
  assign timer_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      err_flag_q <= 1'b0;
      fail_cnt   <= 2'd0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
    end else if (st_q == StLockout) begin
      // Keys are ignored here; only the timer (when built in) leaves this state.
      if (timer_done) begin
        st_q     <= StIdle;
        fail_cnt <= 2'd0;
        alarm    <= 1'b0;
      end
    end else if (key_valid) begin
      unique case (st_q)
        StIdle: begin
          if (is_digit(in_code)) begin
            st_q       <= StV1;
            err_flag_q <= (in_code == CODE_MISS);
          end
        end
        StV1, StV2, StV3: begin
          if (is_digit(in_code)) begin
            st_q       <= st_e'(st_q + 5'd1);
            err_flag_q <= err_flag_q | (in_code == CODE_MISS);
          end else if (in_code == CODE_STAR) begin
            st_q <= StIdle;
          end else begin
            fail_cnt <= fail_inc;
            if (fail_inc == MaxFail) begin
              st_q  <= StLockout;
              alarm <= 1'b1;
            end else begin
              st_q <= StIdle;
            end
          end
        end
        StV4: begin
          if (in_code == CODE_STAR) begin
            st_q <= StIdle;
          end else if (in_code == CODE_HASH) begin
            if (!err_flag_q) begin
              st_q     <= StOpen;
              fail_cnt <= 2'd0;
              unlocked <= 1'b1;
            end else begin
              fail_cnt <= fail_inc;
              if (fail_inc == MaxFail) begin
                st_q  <= StLockout;
                alarm <= 1'b1;
              end else begin
                st_q <= StIdle;
              end
            end
          end
        end
        StOpen: begin
          if (in_code == CODE_STAR) begin
            st_q     <= StS0;
            unlocked <= 1'b0;
          end else if (in_code == CODE_HASH) begin
            st_q     <= StIdle;
            unlocked <= 1'b0;
          end
        end
        StS0, StS1, StS2, StS3: begin
          if (is_digit(in_code)) begin
            st_q <= st_e'(st_q + 5'd1);
          end else if (in_code == CODE_STAR) begin
            st_q     <= StOpen;
            unlocked <= 1'b1;
          end
        end
        StS4: begin
          if (in_code == CODE_HASH) begin
            st_q <= StIdle;
          end else if (in_code == CODE_STAR) begin
            st_q     <= StOpen;
            unlocked <= 1'b1;
          end
        end
        default: begin
          st_q     <= StIdle;
          unlocked <= 1'b0;
          alarm    <= 1'b0;
        end
      endcase
    end
  end

  assign st = st_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl; expectations are queued as keys are driven and compared by
// a monitor on the following falling edge.
module tb_lock_ctrl;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [1:0] in_code;
  logic [4:0] st;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_cnt;

  typedef struct {
    string      tag;
    logic [4:0] st;
    logic       un;
    logic       al;
    logic [1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  lock_ctrl #(
    .MAX_FAIL      (3),
    .LOCKOUT_CYCLES(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .in_code  (in_code),
    .st       (st),
    .unlocked (unlocked),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge after the accepting edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq({e.tag, ".st"}, 32'(st), 32'(e.st));
      check_eq({e.tag, ".unlocked"}, 32'(unlocked), 32'(e.un));
      check_eq({e.tag, ".alarm"}, 32'(alarm), 32'(e.al));
      check_eq({e.tag, ".fail_cnt"}, 32'(fail_cnt), 32'(e.fc));
    end
  end

  task automatic push(input string tag, input logic [4:0] s, input logic un, input logic al,
                      input logic [1:0] fc);
    exp_t e;
    e.tag = tag;
    e.st  = s;
    e.un  = un;
    e.al  = al;
    e.fc  = fc;
    exp_q.push_back(e);
  endtask

  task automatic key(input string tag, input logic [1:0] code, input logic [4:0] s,
                     input logic un, input logic al, input logic [1:0] fc);
    @(negedge clk);
    key_valid = 1'b1;
    in_code   = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    push(tag, s, un, al, fc);
  endtask

  task automatic tick(input string tag, input logic [4:0] s, input logic un, input logic al,
                      input logic [1:0] fc);
    @(posedge clk);
    #1;
    push(tag, s, un, al, fc);
  endtask

  // Reset asserted together with a digit key: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b1;
    in_code   = 2'b00;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    key_valid = 1'b0;
    push(tag, 5'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic bad_entry(input string tag, input logic [1:0] fc_after);
    key({tag, ".k1"}, 2'b00, 5'd1, 1'b0, 1'b0, fc_after - 2'd1);
    key({tag, ".k2"}, 2'b01, 5'd2, 1'b0, 1'b0, fc_after - 2'd1);
    key({tag, ".k3"}, 2'b00, 5'd3, 1'b0, 1'b0, fc_after - 2'd1);
    key({tag, ".k4"}, 2'b00, 5'd4, 1'b0, 1'b0, fc_after - 2'd1);
    if (fc_after == 2'd3) key({tag, ".hash"}, 2'b11, 5'd11, 1'b0, 1'b1, 2'd3);
    else                  key({tag, ".hash"}, 2'b11, 5'd0, 1'b0, 1'b0, fc_after);
  endtask

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    in_code   = 2'b00;

    do_reset("rst0");
    key("idle_star", 2'b10, 5'd0, 1'b0, 1'b0, 2'd0);
    key("idle_hash", 2'b11, 5'd0, 1'b0, 1'b0, 2'd0);

    // Correct code opens.
    key("ok.k1", 2'b00, 5'd1, 1'b0, 1'b0, 2'd0);
    key("ok.k2", 2'b00, 5'd2, 1'b0, 1'b0, 2'd0);
    key("ok.k3", 2'b00, 5'd3, 1'b0, 1'b0, 2'd0);
    key("ok.k4", 2'b00, 5'd4, 1'b0, 1'b0, 2'd0);
    key("ok.hash", 2'b11, 5'd5, 1'b1, 1'b0, 2'd0);
    key("open_digit", 2'b01, 5'd5, 1'b1, 1'b0, 2'd0);

    // New password entry.
    key("np.star", 2'b10, 5'd6, 1'b0, 1'b0, 2'd0);
    key("np.hash_ign", 2'b11, 5'd6, 1'b0, 1'b0, 2'd0);
    key("np.d1", 2'b01, 5'd7, 1'b0, 1'b0, 2'd0);
    key("np.d2", 2'b00, 5'd8, 1'b0, 1'b0, 2'd0);
    key("np.d3", 2'b01, 5'd9, 1'b0, 1'b0, 2'd0);
    key("np.d4", 2'b00, 5'd10, 1'b0, 1'b0, 2'd0);
    key("s4_digit", 2'b00, 5'd10, 1'b0, 1'b0, 2'd0);
    key("s4_star", 2'b10, 5'd5, 1'b1, 1'b0, 2'd0);
    key("ab.star", 2'b10, 5'd6, 1'b0, 1'b0, 2'd0);
    key("ab.abort", 2'b10, 5'd5, 1'b1, 1'b0, 2'd0);
    key("np2.star", 2'b10, 5'd6, 1'b0, 1'b0, 2'd0);
    key("np2.d1", 2'b00, 5'd7, 1'b0, 1'b0, 2'd0);
    key("np2.d2", 2'b00, 5'd8, 1'b0, 1'b0, 2'd0);
    key("np2.d3", 2'b00, 5'd9, 1'b0, 1'b0, 2'd0);
    key("np2.d4", 2'b00, 5'd10, 1'b0, 1'b0, 2'd0);
    key("np2.commit", 2'b11, 5'd0, 1'b0, 1'b0, 2'd0);

    // Three bad entries lead to lockout.
    bad_entry("bad1", 2'd1);
    bad_entry("bad2", 2'd2);
    bad_entry("bad3", 2'd3);

    // Keys ignored in lockout (cycles 2..5 of the lockout).
    key("lk.00", 2'b00, 5'd11, 1'b0, 1'b1, 2'd3);
    key("lk.01", 2'b01, 5'd11, 1'b0, 1'b1, 2'd3);
    key("lk.10", 2'b10, 5'd11, 1'b0, 1'b1, 2'd3);
    key("lk.11", 2'b11, 5'd11, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) tick("lk.hold", 5'd11, 1'b0, 1'b1, 2'd3);
`ifdef LOCK_CTRL_LOCKOUT_TIMER_EN
    tick("lk.expire", 5'd0, 1'b0, 1'b0, 2'd0);
`else
    repeat (100) @(posedge clk);
    tick("lk.persist", 5'd11, 1'b0, 1'b1, 2'd3);
`endif

    // Reset in V2 together with a digit, then '#' in V2 counts a failure.
    do_reset("rst1");
    key("v2.k1", 2'b00, 5'd1, 1'b0, 1'b0, 2'd0);
    key("v2.k2", 2'b00, 5'd2, 1'b0, 1'b0, 2'd0);
    do_reset("rst_v2");
    key("v2b.k1", 2'b00, 5'd1, 1'b0, 1'b0, 2'd0);
    key("v2b.k2", 2'b00, 5'd2, 1'b0, 1'b0, 2'd0);
    key("v2b.hash", 2'b11, 5'd0, 1'b0, 1'b0, 2'd1);
    key("v2c.k1", 2'b00, 5'd1, 1'b0, 1'b0, 2'd1);
    key("v2c.star", 2'b10, 5'd0, 1'b0, 1'b0, 2'd1);

    // Successful entry clears fail count; digits in V4 ignored.
    key("ok2.k1", 2'b00, 5'd1, 1'b0, 1'b0, 2'd1);
    key("ok2.k2", 2'b00, 5'd2, 1'b0, 1'b0, 2'd1);
    key("ok2.k3", 2'b00, 5'd3, 1'b0, 1'b0, 2'd1);
    key("ok2.k4", 2'b00, 5'd4, 1'b0, 1'b0, 2'd1);
    key("ok2.v4_miss", 2'b01, 5'd4, 1'b0, 1'b0, 2'd1);
    key("ok2.hash", 2'b11, 5'd5, 1'b1, 1'b0, 2'd0);
    key("relock", 2'b11, 5'd0, 1'b0, 1'b0, 2'd0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check_eq("drain", 32'(exp_q.size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
